// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide controller and datapath:
// state encoding, operation select and default iteration counts.
package multdiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int MULT_ITERS_DEF = 16;
    localparam int DIV_ITERS_DEF  = 32;
    localparam int ITER_W_DEF     = 6;

endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration counter: synchronous clear (priority over enable), enable, and
// a terminal-count flag for a runtime limit (cnt == limit-1).
module multdiv_iter_counter #(
    parameter int ITER_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [ITER_W:0]   limit,
    output logic [ITER_W-1:0] cnt,
    output logic              tc
);

    logic [ITER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + ITER_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // limit is one bit wider so a full 2^ITER_W iteration count is representable
    assign tc  = ({1'b0, cnt_q} == (limit - (ITER_W+1)'(1)));
    assign cnt = cnt_q;

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the multi-cycle multiply/divide datapath: LOAD, RUN for a fixed
// iteration count, one FIXUP cycle, then a one-cycle ready pulse in DONE.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int MULT_ITERS = MULT_ITERS_DEF,
    parameter int DIV_ITERS  = DIV_ITERS_DEF,
    parameter int ITER_W     = ITER_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    input  logic              divisor_zero,
    output logic              ld_operands,
    output logic              step_en,
    output logic              fix_en,
    output logic              op_is_div,
    output logic [ITER_W-1:0] iter,
    output logic              busy,
    output logic              data_resultRDY,
    output logic              data_exception
);

    state_e state_q, state_d;
    logic   op_q, op_d;
    logic   exc_q, exc_d;
    logic   ld_q, step_q, fix_q, rdy_q, exc_out_q, busy_q;

    logic              start;
    logic              tc;
    logic              cnt_clr;
    logic              cnt_en;
    logic [ITER_W:0]   limit;

    assign start   = ctrl_MULT | ctrl_DIV;
    assign limit   = (op_q == OP_DIV) ? (ITER_W+1)'(DIV_ITERS) : (ITER_W+1)'(MULT_ITERS);
    assign cnt_en  = (state_q == ST_RUN);
    assign cnt_clr = start | ((state_q == ST_RUN) & tc);

    multdiv_iter_counter #(.ITER_W(ITER_W)) u_iter (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (limit),
        .cnt   (iter),
        .tc    (tc)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        exc_d   = exc_q;
        case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_LOAD: begin
                if ((op_q == OP_DIV) && divisor_zero) begin
                    exc_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:   if (tc) state_d = ST_FIXUP;
            ST_FIXUP: state_d = ST_DONE;
            ST_DONE: begin
                state_d = ST_IDLE;
                exc_d   = 1'b0;
            end
            default:  state_d = ST_IDLE;
        endcase
        // A start from any state aborts whatever is in flight
        if (start) begin
            state_d = ST_LOAD;
            op_d    = ctrl_MULT ? OP_MULT : OP_DIV;
            exc_d   = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MULT;
            exc_q     <= 1'b0;
            ld_q      <= 1'b0;
            step_q    <= 1'b0;
            fix_q     <= 1'b0;
            rdy_q     <= 1'b0;
            exc_out_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            exc_q     <= exc_d;
            ld_q      <= (state_d == ST_LOAD);
            step_q    <= (state_d == ST_RUN);
            fix_q     <= (state_d == ST_FIXUP);
            rdy_q     <= (state_d == ST_DONE);
            exc_out_q <= (state_d == ST_DONE) & exc_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign ld_operands    = ld_q;
    assign step_en        = step_q;
    assign fix_en         = fix_q;
    assign data_resultRDY = rdy_q;
    assign data_exception = exc_out_q;
    assign busy           = busy_q;
    assign op_is_div      = op_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl at default parameters.
module tb_multdiv_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ctrl_MULT = 1'b0;
    logic       ctrl_DIV = 1'b0;
    logic       divisor_zero = 1'b0;
    logic       ld_operands, step_en, fix_en, op_is_div, busy;
    logic       data_resultRDY, data_exception;
    logic [5:0] iter;

    int tests = 0;
    int fails = 0;

    multdiv_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .divisor_zero   (divisor_zero),
        .ld_operands    (ld_operands),
        .step_en        (step_en),
        .fix_en         (fix_en),
        .op_is_div      (op_is_div),
        .iter           (iter),
        .busy           (busy),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception)
    );

    always #5 clock = ~clock;

    // {ld, step, fix, rdy, exc, busy, op}
    logic [6:0] obs_v;
    assign obs_v = {ld_operands, step_en, fix_en, data_resultRDY, data_exception, busy, op_is_div};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input logic [6:0] exp_v, input logic [5:0] exp_iter);
        chk({tag, " outs"}, 32'(obs_v), 32'(exp_v));
        chk({tag, " iter"}, 32'(iter), 32'(exp_iter));
    endtask

    // Called in the LOAD cycle (start was in the previous cycle). Walks the
    // whole operation; optionally issues a divide start in the DONE cycle.
    task automatic check_op(input string tag, input logic is_div, input int n, input logic restart);
        chk_cyc({tag, " load"}, {6'b100001, is_div}, 6'd0);
        for (int i = 0; i < n; i++) begin
            step();
            chk_cyc($sformatf("%s run%0d", tag, i), {6'b010001, is_div}, 6'(i));
        end
        step();
        chk_cyc({tag, " fix"}, {6'b001001, is_div}, 6'd0);
        step();
        chk_cyc({tag, " rdy"}, {6'b000101, is_div}, 6'd0);
        if (restart) ctrl_DIV = 1'b1;
        step();
        ctrl_DIV = 1'b0;
        if (restart)
            chk_cyc({tag, " reload"}, 7'b1000011, 6'd0);
        else
            chk_cyc({tag, " idle"}, {6'b000000, is_div}, 6'd0);
    endtask

    initial begin
        // Reset with a start strobe held high
        #1;
        ctrl_MULT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cyc($sformatf("reset%0d", i), 7'b0000000, 6'd0);
        end
        reset = 1'b0;
        ctrl_MULT = 1'b0;
        step();
        chk_cyc("post_reset", 7'b0000000, 6'd0);
        step();
        chk_cyc("post_reset2", 7'b0000000, 6'd0);

        // Multiply: ready in cycle 19, idle in cycle 20
        ctrl_MULT = 1'b1;
        step();
        ctrl_MULT = 1'b0;
        check_op("mult", 1'b0, 16, 1'b0);

        // Divide, nonzero divisor: 32 steps
        ctrl_DIV = 1'b1;
        step();
        ctrl_DIV = 1'b0;
        check_op("div", 1'b1, 32, 1'b0);

        // Divide by zero: ready+exception in cycle 2
        ctrl_DIV = 1'b1;
        step();
        ctrl_DIV = 1'b0;
        divisor_zero = 1'b1;
        chk_cyc("dz load", 7'b1000011, 6'd0);
        step();
        chk_cyc("dz done", 7'b0001111, 6'd0);
        divisor_zero = 1'b0;
        step();
        chk_cyc("dz idle", 7'b0000001, 6'd0);

        // Multiply aborted by a divide start in cycle 10 (iter 8)
        ctrl_MULT = 1'b1;
        step();
        ctrl_MULT = 1'b0;
        chk_cyc("abort load", 7'b1000010, 6'd0);
        for (int i = 0; i < 9; i++) begin
            step();
            chk_cyc($sformatf("abort run%0d", i), 7'b0100010, 6'(i));
        end
        ctrl_DIV = 1'b1;
        step();
        ctrl_DIV = 1'b0;
        check_op("abort div", 1'b1, 32, 1'b0);

        // Both strobes together: multiply wins
        ctrl_MULT = 1'b1;
        ctrl_DIV = 1'b1;
        step();
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        check_op("both", 1'b0, 16, 1'b0);

        // Start during DONE: ready still fires, LOAD follows
        ctrl_MULT = 1'b1;
        step();
        ctrl_MULT = 1'b0;
        check_op("restart", 1'b0, 16, 1'b1);
        check_op("restart div", 1'b1, 32, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
